// File: rtl/multdiv_issue_ctrl_if.sv
// multdiv_issue_ctrl_if: pipeline-side and arithmetic-unit-side signals of the mult/div issue stage.
interface multdiv_issue_ctrl_if;
    logic        in_valid;
    logic        in_is_div;
    logic [31:0] in_opA;
    logic [31:0] in_opB;
    logic [4:0]  in_rd;
    logic        flush;
    logic [31:0] unit_opA;
    logic [31:0] unit_opB;
    logic        unit_ctrl_MULT;
    logic        unit_ctrl_DIV;
    logic [31:0] mult_result;
    logic        mult_exception;
    logic        mult_resultRDY;
    logic [31:0] div_result;
    logic        div_exception;
    logic        div_resultRDY;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (
        output in_valid, in_is_div, in_opA, in_opB, in_rd, flush,
               mult_result, mult_exception, mult_resultRDY,
               div_result, div_exception, div_resultRDY,
        input  unit_opA, unit_opB, unit_ctrl_MULT, unit_ctrl_DIV,
               stall, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  in_valid, in_is_div, in_opA, in_opB, in_rd, flush,
               mult_result, mult_exception, mult_resultRDY,
               div_result, div_exception, div_resultRDY,
        output unit_opA, unit_opB, unit_ctrl_MULT, unit_ctrl_DIV,
               stall, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: captures a mult/div op, pulses the unit start, stalls until ready, issues one writeback.
module multdiv_issue_ctrl #(
    parameter logic [4:0]  EXC_REG       = 5'd30,
    parameter logic [31:0] MULT_EXC_CODE = 32'd4,
    parameter logic [31:0] DIV_EXC_CODE  = 32'd5,
    parameter int          GUARD         = 2,
    parameter int          TIMEOUT       = 40
) (
    input logic                 clock,
    input logic                 ctrl_reset,
    multdiv_issue_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state, next;
    logic [31:0] op_a, op_b, result, sel_result;
    logic [4:0]  rd;
    logic        is_div, exc, sel_rdy, sel_exc, guard_ok, timed_out, capture, accept, go;
    logic [CW-1:0] cnt;

    always_comb begin
        sel_rdy    = is_div ? bus.div_resultRDY : bus.mult_resultRDY;
        sel_exc    = is_div ? bus.div_exception : bus.mult_exception;
        sel_result = is_div ? bus.div_result : bus.mult_result;
        guard_ok   = cnt >= CW'(GUARD);
        timed_out  = cnt == CW'(TIMEOUT);
        capture    = state == IDLE && bus.in_valid && !bus.flush;
        accept     = state == WAIT && sel_rdy && guard_ok;
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:  next = capture ? ISSUE : IDLE;
            ISSUE: next = WAIT;
            WAIT:  next = accept || timed_out ? DONE : WAIT;
            DONE:  next = IDLE;
        endcase
        if (bus.flush)
            next = IDLE;
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            op_a   <= '0;
            op_b   <= '0;
            rd     <= '0;
            is_div <= 1'b0;
            result <= '0;
            exc    <= 1'b0;
            cnt    <= '0;
        end else begin
            if (capture) begin
                op_a   <= bus.in_opA;
                op_b   <= bus.in_opB;
                rd     <= bus.in_rd;
                is_div <= bus.in_is_div;
                exc    <= 1'b0;
            end
            if (state == ISSUE)
                cnt <= '0;
            else if (state == WAIT)
                cnt <= cnt + CW'(1);
            // A ready that arrives on the timeout cycle still wins over the abort.
            if (accept) begin
                result <= sel_result;
                exc    <= sel_exc;
            end else if (state == WAIT && timed_out)
                exc <= 1'b1;
        end
    end

    always_comb begin
        go                 = !ctrl_reset && !bus.flush;
        bus.unit_opA       = op_a;
        bus.unit_opB       = op_b;
        bus.unit_ctrl_MULT = go && state == ISSUE && !is_div;
        bus.unit_ctrl_DIV  = go && state == ISSUE && is_div;
        bus.stall          = !ctrl_reset && (state == IDLE ? bus.in_valid : go && (state == ISSUE || state == WAIT));
        bus.wb_valid       = go && state == DONE && (exc || rd != 5'd0);
        bus.wb_rd          = !ctrl_reset && state == DONE ? (exc ? EXC_REG : rd) : 5'd0;
        bus.wb_data        = !ctrl_reset && state == DONE ? (exc ? (is_div ? DIV_EXC_CODE : MULT_EXC_CODE) : result) : 32'd0;
    end
endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb_multdiv_issue_ctrl: directed plus random mult/div ops; a queue scoreboard checks every writeback.
module tb_multdiv_issue_ctrl;
    localparam int GUARD   = 2;
    localparam int TIMEOUT = 40;
    localparam int NEVER   = 999;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    bit   in_done = 1'b0;
    wb_t  exp_q[$];

    multdiv_issue_ctrl_if bus();

    multdiv_issue_ctrl dut (
        .clock(clk),
        .ctrl_reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b);
        return b == 32'd0 ? 32'd0 : 32'($signed(a) / $signed(b));
    endfunction

    // Plays both arithmetic units; the unselected one gets random noise.
    task automatic drive_units(input bit d, input bit rdy, input bit ex, input logic [31:0] res);
        if (d) begin
            bus.div_resultRDY  = rdy;
            bus.div_exception  = ex;
            bus.div_result     = res;
            bus.mult_resultRDY = 1'($urandom_range(1));
            bus.mult_exception = 1'($urandom_range(1));
            bus.mult_result    = $urandom;
        end else begin
            bus.mult_resultRDY = rdy;
            bus.mult_exception = ex;
            bus.mult_result    = res;
            bus.div_resultRDY  = 1'($urandom_range(1));
            bus.div_exception  = 1'($urandom_range(1));
            bus.div_result     = $urandom;
        end
    endtask

    task automatic quiet_units();
        bus.mult_resultRDY = 1'b0;
        bus.mult_exception = 1'b0;
        bus.mult_result    = '0;
        bus.div_resultRDY  = 1'b0;
        bus.div_exception  = 1'b0;
        bus.div_result     = '0;
    endtask

    // One instruction from capture to return-to-IDLE. rdy_at is the WAIT cycle index of the fresh ready.
    task automatic op(input bit d, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                      input int rdy_at, input bit ex, input int flush_at, input bit fdone, input bit stale);
        logic [31:0] ua, ub, res;
        bit fl, done, tout, eex;
        wb_t e;
        fl = 1'b0;
        done = 1'b0;
        tout = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_is_div = d;
        bus.in_opA    = a;
        bus.in_opB    = b;
        bus.in_rd     = r;
        bus.flush     = 1'b0;
        drive_units(d, stale, 1'($urandom_range(1)), $urandom);
        #1;
        chk("capture_stall", 32'(bus.stall), 32'd1);
        cyc();
        chk("issue_mult", 32'(bus.unit_ctrl_MULT), 32'(!d));
        chk("issue_div", 32'(bus.unit_ctrl_DIV), 32'(d));
        chk("issue_stall", 32'(bus.stall), 32'd1);
        chk("unit_opA", bus.unit_opA, a);
        chk("unit_opB", bus.unit_opB, b);
        ua = bus.unit_opA;
        ub = bus.unit_opB;
        res = d ? sdiv(ua, ub) : ua * ub;
        cyc();
        for (int k = 0; k <= TIMEOUT; k++) begin
            fl = k == flush_at;
            bus.flush = fl;
            if (k == rdy_at)
                drive_units(d, 1'b1, ex, res);
            else
                drive_units(d, stale && k < GUARD, 1'($urandom_range(1)), $urandom);
            #1;
            chk("wait_stall", 32'(bus.stall), 32'(!fl));
            chk("wait_start", {30'd0, bus.unit_ctrl_MULT, bus.unit_ctrl_DIV}, 32'd0);
            cyc();
            if (fl)
                break;
            if (k == rdy_at && k >= GUARD) begin
                done = 1'b1;
                break;
            end
            if (k == TIMEOUT) begin
                done = 1'b1;
                tout = 1'b1;
            end
        end
        quiet_units();
        bus.flush = 1'b0;
        if (done) begin
            eex = tout || ex;
            e.rd   = eex ? 5'd30 : r;
            e.data = eex ? (d ? 32'd5 : 32'd4) : (d ? sdiv(a, b) : a * b);
            if (!fdone && (eex || r != 5'd0))
                exp_q.push_back(e);
            bus.flush = fdone;
            in_done = 1'b1;
            #1;
            chk("done_stall", 32'(bus.stall), 32'd0);
            chk("done_wb_valid", 32'(bus.wb_valid), 32'(!fdone && (eex || r != 5'd0)));
            cyc();
            in_done = 1'b0;
            bus.flush = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.wb_valid === 1'b1) begin
            if (!in_done || exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wb_unexpected: rd %0d data %h with nothing expected at %0t", bus.wb_rd, bus.wb_data, $time);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
                chk("wb_data", bus.wb_data, e.data);
            end
        end
    end

    initial begin
        bit d, ex, fdone, stale;
        logic [31:0] a, b;
        logic [4:0] r;
        int rdy_at, flush_at;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_is_div = 1'b0;
        bus.in_opA = '0;
        bus.in_opB = '0;
        bus.in_rd = '0;
        bus.flush = 1'b0;
        quiet_units();
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("reset_outputs", {bus.stall, bus.wb_valid, bus.unit_ctrl_MULT, bus.unit_ctrl_DIV, bus.wb_rd}, 32'd0);
        chk("reset_opA", bus.unit_opA, 32'd0);
        chk("reset_wb_data", bus.wb_data, 32'd0);
        cyc();

        op(1'b0, 32'd7, -32'sd3, 5'd5, 32, 1'b0, -1, 1'b0, 1'b0);
        op(1'b1, 32'd100, 32'd0, 5'd9, 3, 1'b1, -1, 1'b0, 1'b0);
        op(1'b0, 32'd12, 32'd11, 5'd7, 5, 1'b0, -1, 1'b0, 1'b1);
        op(1'b0, 32'h4000_0000, 32'd4, 5'd0, 2, 1'b0, -1, 1'b0, 1'b0);
        op(1'b1, 32'd50, 32'd7, 5'd4, 10, 1'b0, 5, 1'b0, 1'b0);
        op(1'b0, 32'd3, 32'd5, 5'd6, 2, 1'b0, -1, 1'b0, 1'b0);
        op(1'b1, 32'd9, 32'd3, 5'd8, NEVER, 1'b0, -1, 1'b0, 1'b0);
        op(1'b0, 32'd9, 32'd3, 5'd8, 4, 1'b0, -1, 1'b1, 1'b0);
        cyc();

        // Reset in the middle of WAIT, then a fresh divide.
        bus.in_valid = 1'b1;
        bus.in_is_div = 1'b0;
        bus.in_opA = 32'hDEAD_BEEF;
        bus.in_opB = 32'h1234_5678;
        bus.in_rd = 5'd11;
        repeat (4) cyc();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_cycle_outputs", {bus.stall, bus.wb_valid, bus.unit_ctrl_MULT, bus.unit_ctrl_DIV}, 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_outputs", {bus.stall, bus.wb_valid, bus.wb_rd}, 32'd0);
        chk("post_rst_opA", bus.unit_opA, 32'd0);
        chk("post_rst_opB", bus.unit_opB, 32'd0);
        cyc();
        op(1'b1, 32'd20, 32'd6, 5'd3, 6, 1'b0, -1, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            d = 1'($urandom_range(1));
            a = $urandom;
            b = $urandom_range(7) == 0 ? 32'd0 : (d ? 32'($urandom_range(1000)) - 32'd500 : $urandom);
            r = 5'($urandom);
            ex = (d && b == 32'd0) || $urandom_range(7) == 0;
            rdy_at = $urandom_range(11) == 0 ? NEVER : GUARD + $urandom_range(8);
            stale = $urandom_range(3) == 0;
            if (stale && rdy_at == GUARD)
                rdy_at++;
            flush_at = $urandom_range(7) == 0 ? $urandom_range(GUARD + 6) : -1;
            fdone = $urandom_range(9) == 0;
            op(d, a, b, r, rdy_at, ex, flush_at, fdone, stale);
            if ($urandom_range(2) == 0)
                cyc();
        end

        repeat (3) cyc();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
